// File: rtl/record_meter_pkg.sv
// Shared types and sizes for the recording-screen volume meter controller.
package record_meter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RECORD = 2'd1,
      HOLD   = 2'd2,
      DECAY  = 2'd3
   } state_t;

   localparam int NUM_BARS  = 16;
   localparam int LEVEL_W   = 5;
   localparam int MIC_W     = 12;
   localparam int MAX_LEVEL = 16;

   typedef logic [LEVEL_W-1:0] volume_t [NUM_BARS-1:0];

endpackage

// File: rtl/record_meter_ctrl_peak_level_detector.sv
// Per-window peak magnitude tracker; presents the bar level of max(peak, current sample).
module peak_level_detector
   import record_meter_pkg::*;
#(
   parameter int MIC_MID     = 2048,
   parameter int LEVEL_SHIFT = 7
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [MIC_W-1:0]   mic_sample,
   input  logic               sample_valid,
   input  logic               clear,
   output logic [LEVEL_W-1:0] level
);

   localparam logic signed [MIC_W:0] MID_S = (MIC_W+1)'(MIC_MID);

   logic [MIC_W-1:0] mag_p0;
   logic [MIC_W-1:0] max_p0;
   logic [MIC_W-1:0] peak_p1;

   // Distance from the zero-signal midpoint; 0 maps to 2048, which still fits 12 bits.
   function automatic logic [MIC_W-1:0] abs_mag(input logic [MIC_W-1:0] s);
      logic signed [MIC_W:0] diff;
      logic signed [MIC_W:0] neg;
      diff = $signed({1'b0, s}) - MID_S;
      neg  = -diff;
      return diff[MIC_W] ? neg[MIC_W-1:0] : diff[MIC_W-1:0];
   endfunction

   function automatic logic [LEVEL_W-1:0] sat_level(input logic [MIC_W-1:0] m);
      logic [MIC_W-1:0] s;
      s = m >> LEVEL_SHIFT;
      return (s > MIC_W'(MAX_LEVEL)) ? LEVEL_W'(MAX_LEVEL) : s[LEVEL_W-1:0];
   endfunction

   // Stage 0: combinational magnitude and running max
   always_comb begin
      mag_p0 = sample_valid ? abs_mag(mic_sample) : '0;
      max_p0 = (mag_p0 > peak_p1) ? mag_p0 : peak_p1;
      level  = sat_level(max_p0);
   end

   // Stage 1: registered window peak
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         peak_p1 <= '0;
      end else if (sample_valid) begin
         peak_p1 <= max_p0;
      end
   end

endmodule

// File: rtl/record_meter_ctrl.sv
// Recording-screen meter sequencer: windows the mic stream into bar levels and scrolls/holds/decays a 16-bar history.
module record_meter_ctrl
   import record_meter_pkg::*;
#(
   parameter int SAMPLES_PER_BAR = 2000,
   parameter int HOLD_WINDOWS    = 10,
   parameter int MIC_MID         = 2048,
   parameter int LEVEL_SHIFT     = 7
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [MIC_W-1:0]   mic_sample,
   input  logic               sample_valid,
   input  logic               speak_btn,
   output logic [LEVEL_W-1:0] volume [NUM_BARS-1:0],
   output logic [1:0]         state,
   output logic               window_tick
);

   localparam int CNT_W  = (SAMPLES_PER_BAR > 1) ? $clog2(SAMPLES_PER_BAR) : 1;
   localparam int HOLD_W = (HOLD_WINDOWS > 1) ? $clog2(HOLD_WINDOWS) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SAMPLES_PER_BAR - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_WINDOWS - 1);

   state_t             fsm_state;
   state_t             fsm_next;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_next;
   logic [HOLD_W-1:0]  hold_cnt;
   logic [HOLD_W-1:0]  hold_next;
   volume_t            vol_q;
   volume_t            vol_next;
   logic               tick_q;
   logic               tick_next;
   logic               peak_clear;
   logic               win_done;
   logic               bars_low;
   logic [LEVEL_W-1:0] level;

   peak_level_detector #(
      .MIC_MID     (MIC_MID),
      .LEVEL_SHIFT (LEVEL_SHIFT)
   ) u_peak (
      .clk          (clk),
      .reset        (reset),
      .mic_sample   (mic_sample),
      .sample_valid (sample_valid),
      .clear        (peak_clear),
      .level        (level)
   );

   assign win_done = sample_valid && (cnt == CNT_LAST);

   // True when the next decay step empties the whole history.
   always_comb begin
      bars_low = 1'b1;
      for (int i = 0; i < NUM_BARS; i++) begin
         if (vol_q[i] > LEVEL_W'(1)) begin
            bars_low = 1'b0;
         end
      end
   end

   always_comb begin
      fsm_next   = fsm_state;
      cnt_next   = cnt;
      hold_next  = hold_cnt;
      vol_next   = vol_q;
      tick_next  = 1'b0;
      peak_clear = 1'b0;

      case (fsm_state)
         IDLE: begin
            cnt_next   = '0;
            hold_next  = '0;
            peak_clear = 1'b1;
            for (int i = 0; i < NUM_BARS; i++) begin
               vol_next[i] = '0;
            end
            if (speak_btn) begin
               fsm_next = RECORD;
            end
         end

         RECORD: begin
            // Release wins over any coincident sample; the partial window is dropped.
            if (!speak_btn) begin
               fsm_next   = HOLD;
               cnt_next   = '0;
               hold_next  = '0;
               peak_clear = 1'b1;
            end else if (sample_valid) begin
               if (win_done) begin
                  for (int i = 0; i < NUM_BARS-1; i++) begin
                     vol_next[i] = vol_q[i+1];
                  end
                  vol_next[NUM_BARS-1] = level;
                  cnt_next   = '0;
                  tick_next  = 1'b1;
                  peak_clear = 1'b1;
               end else begin
                  cnt_next = cnt + 1'b1;
               end
            end
         end

         HOLD, DECAY: begin
            // A press restarts recording from an empty history.
            if (speak_btn) begin
               fsm_next   = RECORD;
               cnt_next   = '0;
               hold_next  = '0;
               peak_clear = 1'b1;
               for (int i = 0; i < NUM_BARS; i++) begin
                  vol_next[i] = '0;
               end
            end else if (sample_valid) begin
               if (win_done) begin
                  cnt_next   = '0;
                  tick_next  = 1'b1;
                  peak_clear = 1'b1;
                  if (fsm_state == HOLD) begin
                     if (hold_cnt == HOLD_LAST) begin
                        hold_next = '0;
                        fsm_next  = DECAY;
                     end else begin
                        hold_next = hold_cnt + 1'b1;
                     end
                  end else begin
                     for (int i = 0; i < NUM_BARS; i++) begin
                        vol_next[i] = (vol_q[i] != '0) ? vol_q[i] - 1'b1 : '0;
                     end
                     if (bars_low) begin
                        fsm_next = IDLE;
                     end
                  end
               end else begin
                  cnt_next = cnt + 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fsm_state <= IDLE;
         cnt       <= '0;
         hold_cnt  <= '0;
         tick_q    <= 1'b0;
         for (int i = 0; i < NUM_BARS; i++) begin
            vol_q[i] <= '0;
         end
      end else begin
         fsm_state <= fsm_next;
         cnt       <= cnt_next;
         hold_cnt  <= hold_next;
         tick_q    <= tick_next;
         vol_q     <= vol_next;
      end
   end

   assign volume      = vol_q;
   assign state       = fsm_state;
   assign window_tick = tick_q;

endmodule

// File: tb/tb_record_meter_ctrl.sv
// Scoreboard bench for record_meter_ctrl: directed scenarios then randomized traffic against a behavioural model.
module tb_record_meter_ctrl;

   localparam int SPB = 4;
   localparam int HW  = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [11:0] mic_sample = 12'd2048;
   logic        sample_valid = 1'b0;
   logic        speak_btn = 1'b0;
   logic [4:0]  volume [15:0];
   logic [1:0]  state;
   logic        window_tick;

   record_meter_ctrl #(
      .SAMPLES_PER_BAR (SPB),
      .HOLD_WINDOWS    (HW),
      .MIC_MID         (2048),
      .LEVEL_SHIFT     (7)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .mic_sample   (mic_sample),
      .sample_valid (sample_valid),
      .speak_btn    (speak_btn),
      .volume       (volume),
      .state        (state),
      .window_tick  (window_tick)
   );

   always #5 clk = ~clk;

   typedef struct {
      int tick;
      int st;
      int vol [16];
   } exp_t;

   exp_t exp_q [$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   // Behavioural model: history as a scrolling queue, mode as a small integer.
   int m_vol [$];
   int m_mode;   // 0 idle, 1 record, 2 hold, 3 decay
   int m_cnt;
   int m_peak;
   int m_hold;
   int b_lvl;

   function automatic int mag_of(input int m);
      return (m >= 2048) ? m - 2048 : 2048 - m;
   endfunction

   function automatic int level_of(input int mg);
      int l;
      l = mg / 128;
      return (l > 16) ? 16 : l;
   endfunction

   task automatic model_clear_hist();
      m_vol = {};
      for (int i = 0; i < 16; i++) m_vol.push_back(0);
   endtask

   task automatic model_step(input int r, input int v, input int m, input int b);
      exp_t e;
      int   all_small;
      e.tick = 0;
      if (r != 0) begin
         m_mode = 0; m_cnt = 0; m_peak = 0; m_hold = 0;
         model_clear_hist();
      end else if (m_mode == 0) begin
         if (b != 0) m_mode = 1;
      end else if (m_mode == 1) begin
         if (b == 0) begin
            m_mode = 2; m_cnt = 0; m_peak = 0; m_hold = 0;
         end else if (v != 0) begin
            if (mag_of(m) > m_peak) m_peak = mag_of(m);
            m_cnt++;
            if (m_cnt == SPB) begin
               void'(m_vol.pop_front());
               m_vol.push_back(level_of(m_peak));
               m_cnt = 0; m_peak = 0; e.tick = 1;
            end
         end
      end else begin
         if (b != 0) begin
            m_mode = 1; m_cnt = 0; m_peak = 0; m_hold = 0;
            model_clear_hist();
         end else if (v != 0) begin
            m_cnt++;
            if (m_cnt == SPB) begin
               m_cnt = 0; e.tick = 1;
               if (m_mode == 2) begin
                  m_hold++;
                  if (m_hold == HW) begin
                     m_mode = 3; m_hold = 0;
                  end
               end else begin
                  all_small = 1;
                  foreach (m_vol[i]) if (m_vol[i] > 1) all_small = 0;
                  foreach (m_vol[i]) if (m_vol[i] > 0) m_vol[i]--;
                  if (all_small != 0) m_mode = 0;
               end
            end
         end
      end
      e.st = m_mode;
      for (int i = 0; i < 16; i++) e.vol[i] = m_vol[i];
      exp_q.push_back(e);
   endtask

   task automatic cyc(input logic r, input logic v, input logic [11:0] m, input logic b);
      @(negedge clk);
      reset = r; sample_valid = v; mic_sample = m; speak_btn = b;
      b_lvl = int'(b);
      model_step(int'(r), int'(v), int'(m), int'(b));
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string name, input int got, input int want);
      n_cmp++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", name, got, want);
      end
   endtask

   task automatic sample(input logic [11:0] m);
      cyc(1'b0, 1'b1, m, speak_btn);
   endtask

   task automatic window(input logic [11:0] m);
      sample(m);
      for (int i = 1; i < SPB; i++) sample(12'd2048);
   endtask

   task automatic strobes(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 12'd2048, 1'b0);
   endtask

   // Monitor: every clocked cycle pops one expectation; history compared on ticks and mode changes.
   initial begin
      exp_t e;
      int   last_st;
      int   bad;
      last_st = 0;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (int'(window_tick) != e.tick) begin
               n_fail++;
               $display("FAIL window_tick @%0t: got %0d, want %0d", $time, window_tick, e.tick);
            end
            n_cmp++;
            if (int'(state) != e.st) begin
               n_fail++;
               $display("FAIL state @%0t: got %0d, want %0d", $time, state, e.st);
            end
            if (e.tick != 0 || window_tick || e.st != last_st) begin
               n_cmp++;
               bad = -1;
               for (int i = 0; i < 16; i++) if (bad < 0 && int'(volume[i]) != e.vol[i]) bad = i;
               if (bad >= 0) begin
                  n_fail++;
                  $display("FAIL volume[%0d] @%0t: got %0d, want %0d", bad, $time, volume[bad], e.vol[bad]);
               end
            end
            last_st = e.st;
         end
      end
   end

   initial begin
      int lvl_sum;
      b_lvl = 0;
      m_mode = 0; m_cnt = 0; m_peak = 0; m_hold = 0;
      model_clear_hist();

      // Reset and press
      cyc(1'b1, 1'b0, 12'd2048, 1'b0);
      cyc(1'b1, 1'b0, 12'd2048, 1'b0);
      settle();
      chk("reset_state", int'(state), 0);
      chk("reset_tick", int'(window_tick), 0);
      lvl_sum = 0;
      for (int i = 0; i < 16; i++) lvl_sum += int'(volume[i]);
      chk("reset_volume_sum", lvl_sum, 0);
      cyc(1'b0, 1'b0, 12'd2048, 1'b1);
      settle();
      chk("press_state", int'(state), 1);

      // Single window
      sample(12'd2048); sample(12'd2048); sample(12'd3072); sample(12'd2048);
      settle();
      chk("single_v15", int'(volume[15]), 8);
      chk("single_tick", int'(window_tick), 1);

      // Clamp and negative swing
      window(12'd0);
      window(12'd4095);
      settle();
      chk("clamp_v15", int'(volume[15]), 15);
      chk("clamp_v14", int'(volume[14]), 16);

      // Scroll overflow
      for (int l = 1; l <= 16; l++) window(12'(2048 - l * 128));
      window(12'(2048 + 3 * 128));
      settle();
      chk("scroll_v0", int'(volume[0]), 2);
      chk("scroll_v14", int'(volume[14]), 16);
      chk("scroll_v15", int'(volume[15]), 3);

      // Release, hold, decay
      cyc(1'b1, 1'b0, 12'd2048, 1'b0);
      cyc(1'b0, 1'b0, 12'd2048, 1'b1);
      window(12'(2048 - 5 * 128));
      sample(12'd0); sample(12'd0);
      cyc(1'b0, 1'b1, 12'd0, 1'b0);
      settle();
      chk("release_state", int'(state), 2);
      chk("release_v15", int'(volume[15]), 5);
      strobes(8);
      settle();
      chk("hold_done_state", int'(state), 3);
      strobes(16);
      settle();
      chk("decay4_v15", int'(volume[15]), 1);
      strobes(4);
      settle();
      chk("decay5_v15", int'(volume[15]), 0);
      chk("decay5_state", int'(state), 0);

      // Press during decay, then reset mid-record
      cyc(1'b0, 1'b0, 12'd2048, 1'b1);
      window(12'(2048 - 5 * 128));
      cyc(1'b0, 1'b0, 12'd2048, 1'b0);
      strobes(8);
      strobes(3);
      cyc(1'b0, 1'b1, 12'd2048, 1'b1);
      settle();
      chk("redo_state", int'(state), 1);
      chk("redo_v15", int'(volume[15]), 0);
      sample(12'd0); sample(12'd0);
      cyc(1'b1, 1'b0, 12'd2048, 1'b1);
      settle();
      chk("midreset_state", int'(state), 0);
      cyc(1'b0, 1'b0, 12'd2048, 1'b1);
      window(12'd2048);
      settle();
      chk("no_carry_v15", int'(volume[15]), 0);

      // Randomized traffic
      for (int n = 0; n < 4000; n++) begin
         logic r, v, b;
         logic [11:0] m;
         r = ($urandom_range(0, 599) == 0);
         b = (b_lvl != 0);
         if (b && $urandom_range(0, 29) == 0) b = 1'b0;
         else if (!b && $urandom_range(0, 99) == 0) b = 1'b1;
         v = ($urandom_range(0, 9) < 7);
         case ($urandom_range(0, 4))
            0:       m = 12'd0;
            1:       m = 12'd4095;
            default: m = 12'($urandom_range(0, 4095));
         endcase
         cyc(r, v, m, b);
      end

      cyc(1'b0, 1'b0, 12'd2048, 1'b0);
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
      #5;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/record_meter_ctrl.md
# record_meter_ctrl

Sequencing controller for the Speak-and-Release recording screen's 16-bar volume meter. It converts the 12-bit microphone sample stream into one 5-bit bar level per window and scrolls the levels into a 16-entry history. While the speak button is released it freezes and then decays the history. Its `volume` output drives the meter renderer's `volume` input directly.

## Interface
**Parameters**
- `SAMPLES_PER_BAR`, default 2000: `sample_valid` strobes per window (bar period).
- `HOLD_WINDOWS`, default 10: windows the frozen history is held after release, before decay starts.
- `MIC_MID`, default 2048: zero-signal midpoint of the unsigned mic sample.
- `LEVEL_SHIFT`, default 7: right shift applied to the peak magnitude to form the level.

**Ports**
- `clk`, input, 1: system clock.
- `reset`, input, 1: synchronous, active-high.
- `mic_sample`, input, 12: unsigned microphone sample. Valid only when `sample_valid` is high.
- `sample_valid`, input, 1: single-cycle strobe, one per new sample.
- `speak_btn`, input, 1: clean, synchronised level. High means speaking.
- `volume`, output, 5 × [15:0] (unpacked): bar levels 0..16. Index 15 is the newest and rightmost bar.
- `state`, output, 2: IDLE=0, RECORD=1, HOLD=2, DECAY=3.
- `window_tick`, output, 1: one-cycle pulse when a window completes in RECORD, HOLD or DECAY.

One clock; reset is synchronous and active-high.

## Operation
- **Magnitude.** mag = (mic ≥ MIC_MID) ? mic−MIC_MID : MIC_MID−mic. It is 12 bits, maximum 2048. level = min(mag >> LEVEL_SHIFT, 16), 5 bits.
- **Window.** A counter `cnt` runs 0..SAMPLES_PER_BAR−1 and advances on each `sample_valid` in any state except IDLE. The sample whose strobe finds `cnt` = SAMPLES_PER_BAR−1 completes the window; `cnt` then wraps to 0.
- **Peak tracking.** `peak` holds the maximum mag seen in the current window, including the completing sample. It restarts at 0 for the next window.
- **IDLE.** `volume` is all zero; `cnt` and `peak` are held at 0. `speak_btn` high → RECORD.
- **RECORD.** At each window completion:
  - Shift left: volume[i] ← volume[i+1] for i = 0..14.
  - volume[15] ← level of the window's peak.
  - volume[0]'s old value is lost.
  - `speak_btn` low → HOLD, with `cnt` and `peak` cleared. The partial window is discarded and no shift occurs.
- **HOLD.** `volume` is frozen. After HOLD_WINDOWS window completions → DECAY.
- **DECAY.** At each window completion, every nonzero bar decrements by 1.
  - If every bar is ≤ 1 before the decrement, the next state is IDLE.
  - An all-zero history on entry also goes to IDLE at the first window.
- **Press from HOLD or DECAY.** `speak_btn` high → RECORD. On the entry cycle `volume` is cleared to zero and `cnt`, `peak` and the hold count are cleared.
- **Priority within a cycle.** reset > `speak_btn` transition > window completion.
  - A `sample_valid` coinciding with the release edge in RECORD is discarded.
  - A window completion coinciding with a press in HOLD/DECAY is ignored.

## Timing
- **Reset value.** `volume` all 0, `state` = IDLE, `window_tick` = 0; `cnt`, `peak` and the hold count are 0.
- **Window latency.** The updated `volume` and `window_tick` become visible on the cycle after the completing `sample_valid`.
- **State changes.** Registered. `state` updates on the cycle after `speak_btn` changes.
- **Throughput.** Back-to-back `sample_valid` strobes on consecutive cycles are fully supported. No internal stalls.
- **Reset mid-operation.** Returns to IDLE and all-zero state on the next edge, regardless of the current state or window position.

## Structure
- **Shared package `record_meter_pkg`:**
  - `state_t` enum with the four states.
  - NUM_BARS = 16, LEVEL_W = 5, MIC_W = 12, MAX_LEVEL = 16.
  - `volume_t` typedef (5-bit level array).
- **Sub-module `peak_level_detector`:**
  - Takes the sample, valid and clear inputs.
  - Contains the magnitude computation, the running max and the shift/clamp to level.
  - Outputs the combinational level of max(`peak`, current mag).
- **Top level** holds the FSM, `cnt`, the hold counter and the 16-entry history register.

## Test plan
All scenarios use SAMPLES_PER_BAR=4 and HOLD_WINDOWS=2.
1. **Reset.** Assert reset for 2 cycles → `volume` all 0, `state`=0, `window_tick`=0. Raising `speak_btn` gives `state`=1 on the next cycle.
2. **Single window.** In RECORD, samples 2048, 2048, 3072, 2048 → one cycle after the 4th strobe, volume[15]=8, volume[14:0]=0, `window_tick` pulses once.
3. **Clamp and negative swing.** Window with max sample 0 → volume[15]=16. Next window with max 4095 → volume[15]=15, volume[14]=16.
4. **Scroll overflow.** 17 windows with levels 1..16 then 3 → volume[0]=2, volume[14]=16, volume[15]=3. Level 1 is no longer present.
5. **Release, hold, decay.** Sequence:
   - Press, then one full window of level 5.
   - 2 samples of 0, then release → no shift, `state`=2.
   - 8 strobes → `state`=3.
   - 4 further windows → volume[15]=1.
   - 5th window → all bars 0 and `state`=0.
6. **Press during DECAY and reset mid-RECORD.**
   - Press during DECAY → next cycle `state`=1 and `volume` all 0.
   - Reset asserted after 2 samples of a RECORD window → IDLE.
   - A following press plus 4 samples of 2048 gives volume[15]=0 with no carry-over of `peak`.
